// File: rtl/ptw_mem_arbiter_if.sv
// rtl/ptw_mem_arbiter_if.sv - walk request/response and memory read port bundle for ptw_mem_arbiter
interface ptw_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ptw_req0;
  logic                  ptw_req1;
  logic [ADDR_WIDTH-1:0] ptw_addr0;
  logic [ADDR_WIDTH-1:0] ptw_addr1;
  logic [DATA_WIDTH-1:0] ptw_data0;
  logic [DATA_WIDTH-1:0] ptw_data1;
  logic                  ptw_ready0;
  logic                  ptw_ready1;
  logic                  ptw_err0;
  logic                  ptw_err1;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;
  logic                  mem_resp_err;

  modport slave (
    input  ptw_req0, ptw_req1, ptw_addr0, ptw_addr1,
    output ptw_data0, ptw_data1, ptw_ready0, ptw_ready1, ptw_err0, ptw_err1,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
  );

  modport master (
    output ptw_req0, ptw_req1, ptw_addr0, ptw_addr1,
    input  ptw_data0, ptw_data1, ptw_ready0, ptw_ready1, ptw_err0, ptw_err1,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
  );
endinterface

// File: rtl/ptw_mem_arbiter.sv
// rtl/ptw_mem_arbiter.sv - two-port round-robin page-table-walk memory arbiter with response timeout
module ptw_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  ptw_mem_arbiter_if.slave bus,
  output logic             busy
);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} state_t;

  state_t                state, state_next;
  logic                  gnt, gnt_next, last_gnt;
  logic [1:0]            pend, req_in, clr;
  logic [ADDR_WIDTH-1:0] addr_in [2];
  logic [ADDR_WIDTH-1:0] addr_q  [2];
  logic [DATA_WIDTH-1:0] data_q  [2];
  logic                  err_q;
  logic [TW-1:0]         timer;
  logic                  resp_take, resp_timeout;

  assign req_in     = {bus.ptw_req1, bus.ptw_req0};
  assign addr_in[0] = bus.ptw_addr0;
  assign addr_in[1] = bus.ptw_addr1;
  // RESPOND retires the granted port's pending request
  assign clr[0]     = (state == RESPOND) && !gnt;
  assign clr[1]     = (state == RESPOND) && gnt;

  // State and grant registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
    end
  end

  // Next-state: round-robin pick in IDLE, response or timeout in WAIT_RESP
  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    resp_take    = 1'b0;
    resp_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          state_next = ISSUE;
          gnt_next   = (pend == 2'b11) ? ~last_gnt : pend[1];
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready) state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (bus.mem_resp_valid) begin
          resp_take  = 1'b1;
          state_next = RESPOND;
        end else if (TO_EN && (timer == TO_LAST)) begin
          resp_timeout = 1'b1;
          state_next   = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pending latches: a new request in the retire cycle re-arms the port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      addr_q[0] <= '0;
      addr_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_in[i] && (!pend[i] || clr[i])) begin
          pend[i]   <= 1'b1;
          addr_q[i] <= addr_in[i];
        end else if (clr[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Completion data lands in the port register on entry to RESPOND so it is valid with ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      err_q     <= 1'b0;
      last_gnt  <= 1'b1;
      timer     <= '0;
    end else begin
      if (resp_take) begin
        data_q[gnt] <= bus.mem_resp_data;
        err_q       <= bus.mem_resp_err;
      end else if (resp_timeout) begin
        data_q[gnt] <= '0;
        err_q       <= 1'b1;
      end
      if (state == RESPOND) last_gnt <= gnt;
      if ((state == ISSUE) && bus.mem_req_ready) begin
        timer <= '0;
      end else if ((state == WAIT_RESP) && !resp_take && !resp_timeout && (timer != '1)) begin
        timer <= timer + TW'(1);
      end
    end
  end

  assign bus.mem_req_valid = (state == ISSUE);
  assign bus.mem_req_addr  = (state == ISSUE) ? addr_q[gnt] : '0;
  assign bus.ptw_ready0    = clr[0];
  assign bus.ptw_ready1    = clr[1];
  assign bus.ptw_err0      = clr[0] && err_q;
  assign bus.ptw_err1      = clr[1] && err_q;
  assign bus.ptw_data0     = data_q[0];
  assign bus.ptw_data1     = data_q[1];
  assign busy              = (state != IDLE) || (|pend);
endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// tb/tb_ptw_mem_arbiter.sv - directed self-checking bench for ptw_mem_arbiter
module tb_ptw_mem_arbiter;
  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   failures;
  int   rc0, rc1, both;

  ptw_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifc ();

  ptw_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifc),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completion pulses per port and any cycle with both ports completing
  always @(negedge clk) begin
    if (ifc.ptw_ready0) rc0++;
    if (ifc.ptw_ready1) rc1++;
    if (ifc.ptw_ready0 && ifc.ptw_ready1) both++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.ptw_req0 = 0; ifc.ptw_req1 = 0;
    ifc.ptw_addr0 = '0; ifc.ptw_addr1 = '0;
    ifc.mem_req_ready = 0; ifc.mem_resp_valid = 0;
    ifc.mem_resp_data = '0; ifc.mem_resp_err = 0;
    step(); step();
    checks++; if (ifc.mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", ifc.mem_req_valid); end
    checks++; if ({ifc.ptw_ready0, ifc.ptw_ready1, ifc.ptw_err0, ifc.ptw_err1} !== 4'b0) begin failures++; $display("FAIL reset_ready_err: got %b expected 0000", {ifc.ptw_ready0, ifc.ptw_ready1, ifc.ptw_err0, ifc.ptw_err1}); end
    checks++; if (ifc.ptw_data0 !== 32'h0 || ifc.ptw_data1 !== 32'h0) begin failures++; $display("FAIL reset_data: got %h %h expected 0 0", ifc.ptw_data0, ifc.ptw_data1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int c0, c1;
    c0 = rc0; c1 = rc1;
    ifc.ptw_req0 = 1; ifc.ptw_addr0 = 32'h8000_1004;
    step();
    ifc.ptw_req0 = 0; ifc.ptw_addr0 = '0;
    checks++; if (busy !== 1'b1 || ifc.mem_req_valid !== 1'b0) begin failures++; $display("FAIL single_n1: got busy=%b valid=%b expected 1 0", busy, ifc.mem_req_valid); end
    step();
    checks++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== 32'h8000_1004) begin failures++; $display("FAIL single_issue: got valid=%b addr=%h expected 1 80001004", ifc.mem_req_valid, ifc.mem_req_addr); end
    ifc.mem_req_ready = 1;
    step();
    ifc.mem_req_ready = 0;
    ifc.mem_resp_valid = 1; ifc.mem_resp_data = 32'h2000_04CF; ifc.mem_resp_err = 0;
    step();
    ifc.mem_resp_valid = 0; ifc.mem_resp_data = '0;
    checks++; if (ifc.ptw_ready0 !== 1'b1 || ifc.ptw_data0 !== 32'h2000_04CF || ifc.ptw_err0 !== 1'b0 || ifc.ptw_ready1 !== 1'b0) begin failures++; $display("FAIL single_respond: got rdy0=%b data0=%h err0=%b rdy1=%b expected 1 200004cf 0 0", ifc.ptw_ready0, ifc.ptw_data0, ifc.ptw_err0, ifc.ptw_ready1); end
    step();
    checks++; if (ifc.ptw_ready0 !== 1'b0 || ifc.ptw_data0 !== 32'h2000_04CF || busy !== 1'b0) begin failures++; $display("FAIL single_after: got rdy0=%b data0=%h busy=%b expected 0 200004cf 0", ifc.ptw_ready0, ifc.ptw_data0, busy); end
    checks++; if (rc0 != c0 + 1 || rc1 != c1) begin failures++; $display("FAIL single_pulses: got %0d %0d expected %0d %0d", rc0 - c0, rc1 - c1, 1, 0); end
  endtask

  task automatic test_tie(input bit first);
    int c0, c1;
    bit port;
    logic [31:0] exp_addr, exp_data, got_data;
    logic rdy, rdy_other;
    c0 = rc0; c1 = rc1;
    ifc.ptw_req0 = 1; ifc.ptw_addr0 = 32'h100;
    ifc.ptw_req1 = 1; ifc.ptw_addr1 = 32'h200;
    step();
    ifc.ptw_req0 = 0; ifc.ptw_req1 = 0;
    for (int k = 0; k < 2; k++) begin
      port = (k == 0) ? first : ~first;
      exp_addr = port ? 32'h200 : 32'h100;
      exp_data = {8'hC0, 7'd0, first, exp_addr[15:0]};
      if (k == 1) step();
      step();
      checks++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== exp_addr) begin failures++; $display("FAIL tie_issue%0d: got valid=%b addr=%h expected 1 %h", k, ifc.mem_req_valid, ifc.mem_req_addr, exp_addr); end
      ifc.mem_req_ready = 1;
      step();
      ifc.mem_req_ready = 0;
      ifc.mem_resp_valid = 1; ifc.mem_resp_data = exp_data;
      step();
      ifc.mem_resp_valid = 0;
      rdy       = port ? ifc.ptw_ready1 : ifc.ptw_ready0;
      rdy_other = port ? ifc.ptw_ready0 : ifc.ptw_ready1;
      got_data  = port ? ifc.ptw_data1 : ifc.ptw_data0;
      checks++; if (rdy !== 1'b1 || rdy_other !== 1'b0 || got_data !== exp_data) begin failures++; $display("FAIL tie_respond%0d: got rdy=%b other=%b data=%h expected 1 0 %h", k, rdy, rdy_other, got_data, exp_data); end
    end
    step();
    checks++; if (rc0 != c0 + 1 || rc1 != c1 + 1 || busy !== 1'b0) begin failures++; $display("FAIL tie_pulses: got %0d %0d busy=%b expected 1 1 0", rc0 - c0, rc1 - c1, busy); end
  endtask

  task automatic test_backpressure();
    int c0;
    c0 = rc0;
    ifc.ptw_req0 = 1; ifc.ptw_addr0 = 32'h300;
    step();
    ifc.ptw_req0 = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== 32'h300) begin failures++; $display("FAIL bp_hold%0d: got valid=%b addr=%h expected 1 300", k, ifc.mem_req_valid, ifc.mem_req_addr); end
      if (k == 1) begin ifc.ptw_req0 = 1; ifc.ptw_addr0 = 32'h3FF; end
      else begin ifc.ptw_req0 = 0; end
    end
    step();
    checks++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== 32'h300) begin failures++; $display("FAIL bp_accept: got valid=%b addr=%h expected 1 300", ifc.mem_req_valid, ifc.mem_req_addr); end
    ifc.mem_req_ready = 1;
    step();
    ifc.mem_req_ready = 0;
    ifc.mem_resp_valid = 1; ifc.mem_resp_data = 32'h0000_3333;
    step();
    ifc.mem_resp_valid = 0;
    checks++; if (ifc.ptw_ready0 !== 1'b1 || ifc.ptw_data0 !== 32'h0000_3333) begin failures++; $display("FAIL bp_respond: got rdy0=%b data0=%h expected 1 00003333", ifc.ptw_ready0, ifc.ptw_data0); end
    step(); step();
    checks++; if (ifc.mem_req_valid !== 1'b0 || busy !== 1'b0 || rc0 != c0 + 1) begin failures++; $display("FAIL bp_no_reissue: got valid=%b busy=%b pulses=%0d expected 0 0 1", ifc.mem_req_valid, busy, rc0 - c0); end
  endtask

  task automatic test_bus_error();
    ifc.ptw_req0 = 1; ifc.ptw_addr0 = 32'h400;
    step();
    ifc.ptw_req0 = 0;
    step();
    ifc.mem_req_ready = 1;
    step();
    ifc.mem_req_ready = 0;
    ifc.mem_resp_valid = 1; ifc.mem_resp_data = 32'hDEAD_BEEF; ifc.mem_resp_err = 1;
    step();
    ifc.mem_resp_valid = 0; ifc.mem_resp_err = 0;
    checks++; if (ifc.ptw_ready0 !== 1'b1 || ifc.ptw_err0 !== 1'b1 || ifc.ptw_data0 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL buserr_respond: got rdy0=%b err0=%b data0=%h expected 1 1 deadbeef", ifc.ptw_ready0, ifc.ptw_err0, ifc.ptw_data0); end
    step();
    checks++; if (ifc.ptw_err0 !== 1'b0 || ifc.ptw_ready0 !== 1'b0) begin failures++; $display("FAIL buserr_clear: got rdy0=%b err0=%b expected 0 0", ifc.ptw_ready0, ifc.ptw_err0); end
  endtask

  task automatic test_timeout();
    ifc.ptw_req1 = 1; ifc.ptw_addr1 = 32'h500;
    step();
    ifc.ptw_req1 = 0;
    step();
    ifc.mem_req_ready = 1;
    step();
    ifc.mem_req_ready = 0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (ifc.ptw_ready1 !== 1'b0) begin failures++; $display("FAIL timeout_early%0d: got rdy1=%b expected 0", k, ifc.ptw_ready1); end
      step();
    end
    checks++; if (ifc.ptw_ready1 !== 1'b1 || ifc.ptw_err1 !== 1'b1 || ifc.ptw_data1 !== 32'h0) begin failures++; $display("FAIL timeout_respond: got rdy1=%b err1=%b data1=%h expected 1 1 0", ifc.ptw_ready1, ifc.ptw_err1, ifc.ptw_data1); end
    step();
    ifc.mem_resp_valid = 1; ifc.mem_resp_data = 32'h5555_5555;
    step();
    ifc.mem_resp_valid = 0;
    checks++; if (ifc.ptw_ready0 !== 1'b0 || ifc.ptw_ready1 !== 1'b0 || busy !== 1'b0 || ifc.ptw_data1 !== 32'h0) begin failures++; $display("FAIL timeout_late_resp: got rdy=%b%b busy=%b data1=%h expected 00 0 0", ifc.ptw_ready0, ifc.ptw_ready1, busy, ifc.ptw_data1); end
  endtask

  task automatic test_reset_mid();
    int c0, c1;
    ifc.ptw_req1 = 1; ifc.ptw_addr1 = 32'h600;
    step();
    ifc.ptw_req1 = 0;
    step();
    ifc.mem_req_ready = 1;
    step();
    ifc.mem_req_ready = 0;
    rst = 1'b1;
    #1;
    checks++; if (ifc.mem_req_valid !== 1'b0 || busy !== 1'b0 || ifc.ptw_ready1 !== 1'b0 || ifc.ptw_data0 !== 32'h0) begin failures++; $display("FAIL rstmid_async: got valid=%b busy=%b rdy1=%b data0=%h expected 0 0 0 0", ifc.mem_req_valid, busy, ifc.ptw_ready1, ifc.ptw_data0); end
    step();
    rst = 1'b0;
    c0 = rc0; c1 = rc1;
    ifc.mem_resp_valid = 1; ifc.mem_resp_data = 32'h6666_6666;
    step();
    ifc.mem_resp_valid = 0;
    step();
    checks++; if (rc0 != c0 || rc1 != c1 || busy !== 1'b0 || ifc.ptw_data1 !== 32'h0) begin failures++; $display("FAIL rstmid_stale: got pulses %0d %0d busy=%b data1=%h expected 0 0 0 0", rc0 - c0, rc1 - c1, busy, ifc.ptw_data1); end
    ifc.ptw_req0 = 1; ifc.ptw_addr0 = 32'h700;
    step();
    ifc.ptw_req0 = 0;
    step();
    checks++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_req_addr !== 32'h700) begin failures++; $display("FAIL rstmid_issue: got valid=%b addr=%h expected 1 700", ifc.mem_req_valid, ifc.mem_req_addr); end
    ifc.mem_req_ready = 1;
    step();
    ifc.mem_req_ready = 0;
    ifc.mem_resp_valid = 1; ifc.mem_resp_data = 32'h7777_0007;
    step();
    ifc.mem_resp_valid = 0;
    checks++; if (ifc.ptw_ready0 !== 1'b1 || ifc.ptw_data0 !== 32'h7777_0007 || ifc.ptw_err0 !== 1'b0) begin failures++; $display("FAIL rstmid_new_walk: got rdy0=%b data0=%h err0=%b expected 1 77770007 0", ifc.ptw_ready0, ifc.ptw_data0, ifc.ptw_err0); end
    step();
  endtask

  initial begin
    checks = 0; failures = 0;
    rc0 = 0; rc1 = 0; both = 0;
    test_reset();
    test_tie(1'b0);
    test_single();
    test_tie(1'b1);
    test_backpressure();
    test_bus_error();
    test_timeout();
    test_reset_mid();
    checks++; if (both != 0) begin failures++; $display("FAIL dual_ready: got %0d cycles expected 0", both); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ptw_mem_arbiter.md
# ptw_mem_arbiter

Two-port page-table-walk memory arbiter sitting directly downstream of the instruction-side and data-side MMUs. It accepts each MMU's one-cycle walk request (address plus request pulse) and serialises the requests onto a single valid/ready memory read port with round-robin fairness. It returns the PTE word with a one-cycle ready pulse to the originating MMU. A response timeout guarantees forward progress: a hung memory produces an error completion instead of a stalled walk.

## Interface
- ADDR_WIDTH, 32, walk/memory address width
- DATA_WIDTH, 32, PTE word width
- TIMEOUT_CYCLES, 255, max cycles waiting for a memory response; 0 disables the timeout
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ptw_req0 / ptw_req1  in  1  walk request pulse from MMU 0 (instruction) / MMU 1 (data)
- ptw_addr0 / ptw_addr1  in  ADDR_WIDTH  PTE address, sampled when the request is accepted
- ptw_data0 / ptw_data1  out  DATA_WIDTH  returned PTE word, registered, held until that port's next completion
- ptw_ready0 / ptw_ready1  out  1  one-cycle completion pulse
- ptw_err0 / ptw_err1  out  1  valid with ready: bus error or timeout
- mem_req_valid  out  1  memory read request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  ADDR_WIDTH  read address, stable while valid
- mem_resp_valid  in  1  read data valid
- mem_resp_data  in  DATA_WIDTH  read data
- mem_resp_err  in  1  bus error on the response
- busy  out  1  state != IDLE or any pending request

## Operation
- **Per-port pending latch pend[i] and addr_q[i].**
  - ptw_req_i high with pend[i]=0 sets pend[i] and captures ptw_addr_i.
  - ptw_req_i while pend[i]=1 is ignored. Each port has at most one outstanding request.
- **FSM: IDLE, ISSUE, WAIT_RESP, RESPOND.**
- **IDLE:** if any pend is set, pick a grant and go to ISSUE; the grant is latched in gnt.
  - Only one pending: that port wins.
  - Both pending: the port other than last_gnt wins.
  - last_gnt resets to 1, so port 0 wins the first tie.
- **ISSUE:** mem_req_valid=1, mem_req_addr=addr_q[gnt]. When mem_req_ready=1, go to WAIT_RESP and clear the timer.
- **WAIT_RESP:**
  - mem_resp_valid=1: capture data_q=mem_resp_data, err_q=mem_resp_err, go to RESPOND.
  - Otherwise the timer increments. When timer == TIMEOUT_CYCLES-1 with no response (TIMEOUT_CYCLES>0): data_q=0, err_q=1, go to RESPOND.
  - A response arriving in the same cycle as the timeout wins, i.e. it is taken as a normal response.
- **RESPOND:**
  - ptw_ready[gnt]=1, ptw_data[gnt]<=data_q, ptw_err[gnt]=err_q.
  - Clear pend[gnt], set last_gnt=gnt, go to IDLE.
- **mem_resp_valid outside WAIT_RESP** is ignored; no state change.
- **Simultaneous events:**
  - ptw_req_i in the same cycle RESPOND clears pend[i]: the set wins, and the new address is captured.
  - A request arriving on the non-granted port during service is latched and served next.
- **Timer width:** $clog2(TIMEOUT_CYCLES+1), saturating; it never wraps.

## Timing
- **Reset values:** all outputs 0; state IDLE; pend=0; last_gnt=1; timer=0.
- **Reset mid-operation:** mem_req_valid and ready outputs drop asynchronously. The in-flight memory response is ignored afterwards.
- **Minimum latency:** ptw_req_i high in cycle N, then:
  - N+1: pend set, state IDLE
  - N+2: ISSUE (mem_req_valid=1)
  - N+3: WAIT_RESP, with mem_req_ready=1 in N+2
  - N+4: RESPOND, with mem_resp_valid=1 in N+3
  - ptw_ready_i=1 in N+4. Every extra cycle of memory backpressure or delay adds one cycle.
- **Request handshake:** mem_req_valid stays high and mem_req_addr stable until the mem_req_ready cycle. The request is never withdrawn except by reset.
- **Completions:** ptw_ready pulses are exactly one cycle, and never both ports in the same cycle.
- **Data hold:** ptw_data_i updates only on that port's completion and holds otherwise.
- **Back-to-back:** the next ISSUE starts the cycle after RESPOND+1 (IDLE is always visited for one cycle).

## Test plan
- **Single walk, port 0:** ptw_req0 with addr 0x8000_1004; memory ready immediately, returns 0x2000_04CF next cycle -> mem_req_addr=0x8000_1004 in N+2; ptw_ready0=1, ptw_data0=0x2000_04CF, ptw_err0=0 in N+4; ptw_ready1 stays 0.
- **Simultaneous requests:** req0 (0x100) and req1 (0x200) in the same cycle -> port 0 served first, then port 1. Repeat the tie -> port 1 served first (alternation). Exactly one ready pulse per request.
- **Backpressure:** mem_req_ready low for 5 cycles -> addr/valid stable throughout; ready delayed by exactly 5 cycles; a duplicate ptw_req0 during the wait causes no second issue.
- **Bus error:** mem_resp_err=1 with data 0xDEAD_BEEF -> ptw_err0=1 with ptw_ready0 and ptw_data0=0xDEAD_BEEF.
- **Timeout:** TIMEOUT_CYCLES=8, no response -> ptw_ready1=1, ptw_err1=1, ptw_data1=0 exactly 8 cycles after entering WAIT_RESP. A late mem_resp_valid in IDLE is ignored.
- **Reset mid-walk:** assert rst during WAIT_RESP with req1 pending -> all outputs 0 and busy=0 immediately. A subsequent response causes no ready; a new req0 completes normally.
